// File: rtl/fir_dac_spi_out.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_dac_spi_out                                               |
// | Function : saturates FIR output to a DAC code, buffers it in a FIFO and   |
// |            streams it as a mode-0 MSB-first SPI frame.                   |
// | Option   : DAC_OFFSET_BINARY_EN - send offset binary instead of 2's comp. |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fir_dac_spi_out #(
  parameter int IN_WIDTH   = 39,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [IN_WIDTH-1:0]    y_in,
  input  logic                          y_valid,
  input  logic                          clr_flags,
  output logic                          dac_sclk,
  output logic                          dac_cs_n,
  output logic                          dac_mosi,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int c_BIT_W = $clog2(OUT_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // The sample fits the DAC word only if all bits from the DAC sign bit up agree.
  logic [IN_WIDTH-OUT_WIDTH:0] w_top;
  logic                        w_hi;
  logic                        w_lo;
  logic [OUT_WIDTH-1:0]        w_code;
  logic [OUT_WIDTH-1:0]        w_dac;

  assign w_top = y_in[IN_WIDTH-1:OUT_WIDTH-1];
  assign w_hi  = !y_in[IN_WIDTH-1] && (|w_top);
  assign w_lo  = y_in[IN_WIDTH-1] && !(&w_top);

  always_comb begin
    w_code = y_in[OUT_WIDTH-1:0];
    if (w_hi)
      w_code = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (w_lo)
      w_code = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  end

`ifdef DAC_OFFSET_BINARY_EN
  assign w_dac = {~w_code[OUT_WIDTH-1], w_code[OUT_WIDTH-2:0]};
`else
  assign w_dac = w_code;
`endif

  logic                 r_sv;
  logic [OUT_WIDTH-1:0] r_code;
  logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr;
  logic [c_AW-1:0]      r_rd;
  logic [c_AW:0]        r_cnt;
  logic                 r_sat;
  logic                 r_ovf;

  state_t               r_state;
  logic [c_DIV_W-1:0]   r_div;
  logic [c_GAP_W-1:0]   r_gap;
  logic [c_BIT_W-1:0]   r_bits;
  logic [OUT_WIDTH-1:0] r_shift;
  logic                 r_sclk;
  logic                 r_cs_n;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full = (r_cnt == (c_AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_state == ST_IDLE) && (r_cnt != '0);
  assign w_push = r_sv && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sv   <= 1'b0;
      r_code <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sv   <= y_valid;
      r_code <= w_dac;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // Set events take priority over a coincident clear.
      if (y_valid && (w_hi || w_lo)) r_sat <= 1'b1;
      else if (clr_flags)            r_sat <= 1'b0;
      if (r_sv && !w_push)           r_ovf <= 1'b1;
      else if (clr_flags)            r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= r_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_gap   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sclk <= 1'b0;
          r_cs_n <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd];
            r_cs_n  <= 1'b0;
            r_div   <= '0;
            r_bits  <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_div == c_DIV_W'(CLK_DIV-1)) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Zero fill leaves mosi low once the last bit has gone out.
              r_sclk  <= 1'b0;
              r_shift <= {r_shift[OUT_WIDTH-2:0], 1'b0};
              r_bits  <= r_bits + 1'b1;
              if (r_bits == c_BIT_W'(OUT_WIDTH-1)) begin
                r_cs_n  <= 1'b1;
                r_gap   <= '0;
                r_state <= ST_GAP;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap == c_GAP_W'(CS_GAP-1)) r_state <= ST_IDLE;
          else                              r_gap   <= r_gap + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dac_sclk   = r_sclk;
  assign dac_cs_n   = r_cs_n;
  assign dac_mosi   = r_shift[OUT_WIDTH-1];
  assign sat_flag   = r_sat;
  assign ovf_flag   = r_ovf;
  assign fifo_level = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fir_dac_spi_out.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fir_dac_spi_out                                            |
// | Function : scoreboard bench; an SPI monitor decodes frames and compares   |
// |            them against codes queued by the directed stimulus.           |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_fir_dac_spi_out;

  localparam int IN_W = 39;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] E_ZERO = 16'h8000;
  localparam logic [15:0] E_MIN  = 16'h0000;
  localparam logic [15:0] E_MAX  = 16'hFFFF;
`else
  localparam logic [15:0] E_ZERO = 16'h0000;
  localparam logic [15:0] E_MIN  = 16'h8000;
  localparam logic [15:0] E_MAX  = 16'h7FFF;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IN_W-1:0] y_in = '0;
  logic            y_valid = 1'b0;
  logic            clr_flags = 1'b0;
  logic            dac_sclk, dac_cs_n, dac_mosi, sat_flag, ovf_flag;
  logic [2:0]      fifo_level;

  fir_dac_spi_out dut (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .clr_flags  (clr_flags),
    .dac_sclk   (dac_sclk),
    .dac_cs_n   (dac_cs_n),
    .dac_mosi   (dac_mosi),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // SPI monitor: captures mosi on each rising sclk seen while cs_n is low.
  logic        m_prev_cs = 1'b1;
  logic        m_prev_sclk = 1'b0;
  logic        m_inf = 1'b0;
  logic        m_had = 1'b0;
  logic [15:0] m_word = '0;
  int          m_bits = 0, m_low = 0, m_gap = 0;
  int          frames = 0, cs_falls = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_inf       = 1'b0;
      m_had       = 1'b0;
      m_prev_cs   = 1'b1;
      m_prev_sclk = 1'b0;
    end else begin
      if (m_prev_cs && !dac_cs_n) begin
        if (m_had) check("cs_gap_ge2", 32'(m_gap >= 2), 1);
        m_inf  = 1'b1;
        m_bits = 0;
        m_low  = 1;
        m_word = '0;
        cs_falls++;
      end else if (!dac_cs_n && m_inf) begin
        m_low++;
        if (!m_prev_sclk && dac_sclk) begin
          m_word = {m_word[14:0], dac_mosi};
          m_bits++;
        end
      end else if (!m_prev_cs && dac_cs_n && m_inf) begin
        m_inf = 1'b0;
        m_had = 1'b1;
        m_gap = 1;
        frames++;
        check("frame_bits", m_bits, 16);
        check("cs_low_len", m_low, 64);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %04h, required no frame", m_word);
        end else begin
          check("frame_data", m_word, exp_q.pop_front());
        end
      end else if (dac_cs_n) begin
        m_gap++;
      end
      m_prev_cs   = dac_cs_n;
      m_prev_sclk = dac_sclk;
    end
  end

  // Called on a falling clk edge; the strobe spans the next rising edge.
  task automatic strobe(int v, bit clr = 1'b0);
    y_in      = IN_W'(v);
    y_valid   = 1'b1;
    clr_flags = clr;
    @(negedge clk);
    y_valid   = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !dac_cs_n) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: %0d codes still pending, required 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int  f0, cf0, falls, n;
    logic ps;
    logic [2:0] maxl;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", dac_cs_n, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_mosi", dac_mosi, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_level", fifo_level, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single sample and first-frame latency.
    exp_q.push_back(16'h04D2);
    strobe(1234);
    check("cs_high_1", dac_cs_n, 1);
    @(negedge clk);
    check("cs_high_2", dac_cs_n, 1);
    @(negedge clk);
    check("cs_fall_3", dac_cs_n, 0);
    wait_idle();
    check("sat_after_1234", sat_flag, 0);

    // Clipping and flag clear / set priority.
    exp_q.push_back(16'h7FFF);
    strobe(40000);
    check("sat_pos_clip", sat_flag, 1);
    wait_idle();
    exp_q.push_back(16'h8000);
    strobe(-40000);
    wait_idle();
    pulse_clr();
    check("sat_cleared", sat_flag, 0);
    exp_q.push_back(16'h7FFF);
    strobe(50000, 1'b1);
    check("sat_set_wins", sat_flag, 1);
    wait_idle();
    pulse_clr();

    // In-range boundary codes (encoding depends on the build option).
    exp_q.push_back(E_ZERO);
    strobe(0);
    exp_q.push_back(E_MIN);
    strobe(-32768);
    exp_q.push_back(E_MAX);
    strobe(32767);
    wait_idle();
    check("sat_no_clip_bounds", sat_flag, 0);

    // Burst overflow: six back-to-back samples into a four-entry FIFO.
    f0 = frames;
    for (int i = 1; i <= 5; i++) exp_q.push_back(16'(i));
    maxl = '0;
    for (int i = 1; i <= 6; i++) begin
      strobe(i);
      if (fifo_level > maxl) maxl = fifo_level;
    end
    check("burst_level_peak", maxl, 4);
    @(negedge clk);
    check("burst_ovf", ovf_flag, 1);
    wait_idle();
    check("burst_frames", frames - f0, 5);
    pulse_clr();
    check("ovf_cleared", ovf_flag, 0);

    // Asynchronous reset after the 8th falling sclk, two samples queued.
    strobe(100);
    strobe(200);
    strobe(300);
    falls = 0;
    n = 0;
    ps = dac_sclk;
    while (falls < 8 && n < 500) begin
      @(negedge clk);
      if (ps && !dac_sclk) falls++;
      ps = dac_sclk;
      n++;
    end
    check("midframe_falls", falls, 8);
    check("midframe_level", fifo_level, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_cs_n", dac_cs_n, 1);
    check("async_sclk", dac_sclk, 0);
    check("async_level", fifo_level, 0);
    check("async_mosi", dac_mosi, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cf0 = cs_falls;
    repeat (200) @(negedge clk);
    check("no_frame_after_rst", cs_falls - cf0, 0);
    exp_q.push_back(16'd77);
    strobe(77);
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
